alu_mul_sequencer: RTL and testbench
====================================

ALU_MUL_SEQUENCER -- requirements
Module: alu_mul_sequencer

Interface
REQ-001 The block SHALL have no parameters; operand width is fixed at 8x8 -> 16 bits.
REQ-002 The block SHALL use one clock and a synchronous, active-low reset; no other clock or reset SHALL exist.
REQ-003 Clock  in  1  rising-edge system clock.
REQ-004 Reset  in  1  synchronous active-low reset, sampled on rising Clock.
REQ-005 Start  in  1  request pulse; sampled only in IDLE.
REQ-006 MulA  in  8  multiplicand, unsigned; sampled with Start.
REQ-007 MulB  in  8  multiplier, unsigned; sampled with Start.
REQ-008 ALUOut  in  16  combinational result from the shared ALU.
REQ-009 ALU_A  out  16  ALU A operand.
REQ-010 ALU_B  out  16  ALU B operand.
REQ-011 FunSel  out  5  ALU function select (ALU encoding: bit4=1 selects 16-bit ops).
REQ-012 WF  out  1  ALU flag write enable.
REQ-013 Busy  out  1  high in every state except IDLE.
REQ-014 Done  out  1  one-cycle completion pulse.
REQ-015 Product  out  16  registered result; holds until the next completion.

Function
REQ-016 The FSM SHALL have states IDLE, ADD, SHL, SHR, FLAG and DONE; ALU_A, ALU_B, FunSel and WF SHALL be decoded combinationally from the state and the internal registers.
REQ-017 Internal registers: P (16-bit partial product), M (16-bit shifted multiplicand), Q (8-bit multiplier), cnt (3-bit iteration count).
REQ-018 IDLE: ALU_A=0, ALU_B=0, FunSel=10000, WF=0; on Start=1 load M={8'h00,MulA}, Q=MulB, P=0, cnt=0, then go to ADD; on Start=0 stay in IDLE.
REQ-019 ADD: ALU_A=P, ALU_B=M, FunSel=10100 (16-bit A+B), WF=0; if Q[0]=1 then P<=ALUOut, else P is unchanged; go to SHL.
REQ-020 SHL: ALU_A=M, ALU_B=0, FunSel=11011 (16-bit LSL), WF=0; M<=ALUOut; go to SHR.
REQ-021 SHR: ALU_A={8'h00,Q}, ALU_B=0, FunSel=01100 (8-bit LSR), WF=0; Q<=ALUOut[7:0]; cnt<=cnt+1; if cnt=7 go to FLAG, else go to ADD.
REQ-022 FLAG: ALU_A=P, ALU_B=0, FunSel=10000 (pass A), WF=1 for exactly this one cycle, so the ALU captures Z/N of the product; go to DONE.
REQ-023 DONE: Product<=P, Done=1 for one cycle, FunSel=10000, ALU_A=0, WF=0; go to IDLE.
REQ-024 Latency is fixed and independent of the data: with Start sampled at edge 0, the FSM SHALL be in ADD/SHL/SHR for 24 cycles, then FLAG for 1 cycle, and SHALL assert Done in the 26th cycle after edge 0.
REQ-025 A new Start SHALL be accepted in the cycle immediately after DONE, i.e. IDLE for one cycle.
REQ-026 The ALU carry from the ADD state SHALL be ignored; an 8x8 unsigned product cannot exceed 16 bits.
REQ-027 Start, MulA and MulB SHALL be ignored while Busy=1; operands latched at acceptance SHALL NOT change mid-operation.
REQ-028 WF SHALL be 0 in every state except FLAG; the sequencer SHALL never corrupt the ALU flags during iterations.

Reset
REQ-029 Reset=0 at a rising edge SHALL force IDLE and clear P, M, Q, cnt and Product to 0, with Busy=0, Done=0 and WF=0, from any state including mid-operation.
REQ-030 Reset SHALL take priority over Start in the same cycle; an operation aborted by reset SHALL produce no Done and SHALL leave Product=0.

Verification
REQ-031 MulA=13, MulB=11, Start pulsed -> Busy high for 26 cycles, Done at cycle 26, Product=0x008F, ALU flags Z=0, N=0.
REQ-032 MulA=0, MulB=0xA5 -> Product=0x0000, WF pulsed once, Z=1.
REQ-033 MulA=0xFF, MulB=0xFF -> Product=0xFE01, N=1; MulA=0x80, MulB=0x02 -> Product=0x0100.
REQ-034 Start re-pulsed with different operands at cycle 10 of an operation -> it is ignored; the original product is delivered; WF counts exactly 1 per operation.
REQ-035 Reset asserted at cycle 12 -> next cycle Busy=0, Product=0, Done is never seen; Start in the following cycle gives the correct result after 26 cycles.
REQ-036 Back-to-back operations with Start held high -> the second operation starts 1 cycle after Done, and both products are correct.

Source files
------------

// File: rtl/alu_mul_sequencer.sv
// rtl/alu_mul_sequencer.sv - 8x8 shift-add multiplier that drives a shared external ALU
// One ALU operation per cycle: add, shift multiplicand left, shift multiplier right, 8 rounds.
module alu_mul_sequencer (
   input  logic        Clock,
   input  logic        Reset,
   input  logic        Start,
   input  logic [7:0]  MulA,
   input  logic [7:0]  MulB,
   input  logic [15:0] ALUOut,
   output logic [15:0] ALU_A,
   output logic [15:0] ALU_B,
   output logic [4:0]  FunSel,
   output logic        WF,
   output logic        Busy,
   output logic        Done,
   output logic [15:0] Product
);

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      ADD  = 3'd1,
      SHL  = 3'd2,
      SHR  = 3'd3,
      FLAG = 3'd4,
      DONE = 3'd5
   } state_t;

   localparam logic [4:0] FS_PASS16 = 5'b10000;
   localparam logic [4:0] FS_ADD16  = 5'b10100;
   localparam logic [4:0] FS_LSL16  = 5'b11011;
   localparam logic [4:0] FS_LSR8   = 5'b01100;

   state_t      state;
   state_t      state_nxt;
   logic [15:0] p_reg;
   logic [15:0] m_reg;
   logic [7:0]  q_reg;
   logic [2:0]  cnt;

   always_ff @(posedge Clock) begin
      if (!Reset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Datapath registers load straight from the shared ALU result; the ADD carry is dropped.
   always_ff @(posedge Clock) begin
      if (!Reset) begin
         p_reg   <= 16'h0000;
         m_reg   <= 16'h0000;
         q_reg   <= 8'h00;
         cnt     <= 3'd0;
         Product <= 16'h0000;
      end else begin
         case (state)
            IDLE: begin
               if (Start) begin
                  m_reg <= {8'h00, MulA};
                  q_reg <= MulB;
                  p_reg <= 16'h0000;
                  cnt   <= 3'd0;
               end
            end
            ADD: begin
               if (q_reg[0]) begin
                  p_reg <= ALUOut;
               end
            end
            SHL: begin
               m_reg <= ALUOut;
            end
            SHR: begin
               q_reg <= ALUOut[7:0];
               cnt   <= cnt + 3'd1;
            end
            DONE: begin
               Product <= p_reg;
            end
            default: begin
            end
         endcase
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    state_nxt = Start ? ADD : IDLE;
         ADD:     state_nxt = SHL;
         SHL:     state_nxt = SHR;
         SHR:     state_nxt = (cnt == 3'd7) ? FLAG : ADD;
         FLAG:    state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // FLAG replays the final product through the ALU so it latches Z/N exactly once.
   always_comb begin
      ALU_A  = 16'h0000;
      ALU_B  = 16'h0000;
      FunSel = FS_PASS16;
      WF     = 1'b0;
      Busy   = (state != IDLE);
      Done   = 1'b0;
      case (state)
         ADD: begin
            ALU_A  = p_reg;
            ALU_B  = m_reg;
            FunSel = FS_ADD16;
         end
         SHL: begin
            ALU_A  = m_reg;
            FunSel = FS_LSL16;
         end
         SHR: begin
            ALU_A  = {8'h00, q_reg};
            FunSel = FS_LSR8;
         end
         FLAG: begin
            ALU_A  = p_reg;
            WF     = 1'b1;
         end
         DONE: begin
            Done   = 1'b1;
         end
         default: begin
         end
      endcase
   end

endmodule

// File: tb/tb_alu_mul_sequencer.sv
// tb/tb_alu_mul_sequencer.sv - directed bench for alu_mul_sequencer with a behavioural ALU
module tb_alu_mul_sequencer;

   logic        Clock;
   logic        Reset;
   logic        Start;
   logic [7:0]  MulA;
   logic [7:0]  MulB;
   logic [15:0] ALUOut;
   logic [15:0] ALU_A;
   logic [15:0] ALU_B;
   logic [4:0]  FunSel;
   logic        WF;
   logic        Busy;
   logic        Done;
   logic [15:0] Product;

   int checks;
   int errors;
   int wf_cnt;
   int done_cnt;
   logic flag_z;
   logic flag_n;

   alu_mul_sequencer dut (
      .Clock   (Clock),
      .Reset   (Reset),
      .Start   (Start),
      .MulA    (MulA),
      .MulB    (MulB),
      .ALUOut  (ALUOut),
      .ALU_A   (ALU_A),
      .ALU_B   (ALU_B),
      .FunSel  (FunSel),
      .WF      (WF),
      .Busy    (Busy),
      .Done    (Done),
      .Product (Product)
   );

   initial Clock = 1'b0;
   always #5 Clock = ~Clock;

   always_comb begin
      ALUOut = ALU_A;
      case (FunSel)
         5'b10100: ALUOut = ALU_A + ALU_B;
         5'b11011: ALUOut = ALU_A << 1;
         5'b01100: ALUOut = {8'h00, ALU_A[7:0] >> 1};
         default:  ALUOut = ALU_A;
      endcase
   end

   // Flag register of the modelled ALU, plus event counters, sampled mid-cycle.
   initial begin
      wf_cnt   = 0;
      done_cnt = 0;
      flag_z   = 1'b0;
      flag_n   = 1'b0;
      forever begin
         @(negedge Clock);
         if (WF === 1'b1) begin
            wf_cnt++;
            flag_z = (ALUOut == 16'h0000);
            flag_n = ALUOut[15];
         end
         if (Done === 1'b1) done_cnt++;
      end
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge Clock);
      #1;
   endtask

   task automatic wait_done(output int n);
      n = 1;
      while (Done !== 1'b1 && n < 40) begin
         tick();
         n++;
      end
   endtask

   task automatic run_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                         input logic [15:0] exp);
      int n;
      int wf0;
      wf0   = wf_cnt;
      MulA  = a;
      MulB  = b;
      Start = 1'b1;
      tick();
      Start = 1'b0;
      chk({tag, "_busy"}, Busy, 1'b1);
      wait_done(n);
      chk({tag, "_latency"}, n, 26);
      tick();
      chk({tag, "_product"}, Product, exp);
      chk({tag, "_idle"}, Busy, 1'b0);
      chk({tag, "_wf_once"}, wf_cnt - wf0, 1);
   endtask

   initial begin
      int n;
      int wf0;
      int d0;
      checks = 0;
      errors = 0;
      Reset  = 1'b0;
      Start  = 1'b0;
      MulA   = 8'h00;
      MulB   = 8'h00;
      tick();
      tick();
      chk("rst_busy", Busy, 1'b0);
      chk("rst_done", Done, 1'b0);
      chk("rst_wf", WF, 1'b0);
      chk("rst_product", Product, 16'h0000);
      chk("rst_funsel", FunSel, 5'b10000);
      chk("rst_alu_a", ALU_A, 16'h0000);
      Reset = 1'b1;
      tick();

      run_op("m13x11", 8'd13, 8'd11, 16'h008F);
      chk("m13x11_z", flag_z, 1'b0);
      chk("m13x11_n", flag_n, 1'b0);
      run_op("m0xa5", 8'h00, 8'hA5, 16'h0000);
      chk("m0xa5_z", flag_z, 1'b1);
      run_op("mffxff", 8'hFF, 8'hFF, 16'hFE01);
      chk("mffxff_n", flag_n, 1'b1);
      run_op("m80x02", 8'h80, 8'h02, 16'h0100);

      // Start with new operands in cycle 10 must be ignored.
      wf0 = wf_cnt;
      MulA = 8'd7; MulB = 8'd9; Start = 1'b1;
      tick();
      Start = 1'b0;
      repeat (9) tick();
      MulA = 8'hFF; MulB = 8'hFF; Start = 1'b1;
      tick();
      Start = 1'b0;
      wait_done(n);
      chk("restart_done", Done, 1'b1);
      tick();
      chk("restart_product", Product, 16'd63);
      chk("restart_wf_once", wf_cnt - wf0, 1);

      // Reset in cycle 12 aborts the operation silently.
      d0 = done_cnt;
      MulA = 8'h80; MulB = 8'h02; Start = 1'b1;
      tick();
      Start = 1'b0;
      repeat (11) tick();
      Reset = 1'b0;
      tick();
      chk("abort_busy", Busy, 1'b0);
      chk("abort_product", Product, 16'h0000);
      chk("abort_done", Done, 1'b0);
      Reset = 1'b1;
      run_op("post_rst", 8'd12, 8'd12, 16'd144);
      chk("abort_one_done", done_cnt - d0, 1);

      // Reset wins over a simultaneous Start.
      Reset = 1'b0; Start = 1'b1;
      tick();
      chk("rst_vs_start", Busy, 1'b0);
      chk("rst_clr_product", Product, 16'h0000);
      Reset = 1'b1; Start = 1'b0;
      tick();

      // Start held high: second operation begins one cycle after Done.
      MulA = 8'd3; MulB = 8'd5; Start = 1'b1;
      tick();
      MulA = 8'd6; MulB = 8'd7;
      wait_done(n);
      chk("b2b_first_latency", n, 26);
      tick();
      chk("b2b_first_product", Product, 16'd15);
      chk("b2b_gap_idle", Busy, 1'b0);
      tick();
      chk("b2b_second_busy", Busy, 1'b1);
      Start = 1'b0;
      wait_done(n);
      chk("b2b_second_latency", n, 26);
      tick();
      chk("b2b_second_product", Product, 16'd42);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
